rom_rd_ctrl: RTL
================

ROM_RD_CTRL -- requirements
Module: rom_rd_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 8, ROM address width.
REQ-002 SHALL have parameter DWIDTH, default 8, ROM data width.
REQ-003 SHALL have parameter TWIDTH, default 4, request tag width carried alongside each lookup.
REQ-004 SHALL have parameter RD_LAT, default 2, ROM read latency in cycles (address registered in ROM, then data registered).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries; legal range >= 2.
REQ-006 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port in_addr, input, AWIDTH, lookup address.
REQ-009 SHALL have port in_tag, input, TWIDTH, opaque tag returned with the result.
REQ-010 SHALL have port in_valid, input, 1, request present.
REQ-011 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-012 SHALL have port rom_addr, output, AWIDTH, drives ROM address port.
REQ-013 SHALL have port rom_q, input, DWIDTH, ROM read data, RD_LAT cycles after rom_addr.
REQ-014 SHALL have port out_data, output, DWIDTH, lookup result.
REQ-015 SHALL have port out_tag, output, TWIDTH, tag of the request that produced out_data.
REQ-016 SHALL have port out_valid, output, 1, result present.
REQ-017 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.

Function
REQ-018 SHALL drive rom_addr combinationally equal to in_addr; a ROM read is issued on every cycle, but only accepted requests are tracked.
REQ-019 SHALL carry each accepted request through an RD_LAT-stage valid/tag shift pipeline; stage 0 loads on the accept edge, last stage qualifies rom_q.
REQ-020 SHALL write {rom_q, tag} into the output FIFO on the edge ending the cycle where the last pipeline stage is valid.
REQ-021 SHALL have fixed latency: request accepted in cycle T -> out_valid first possible in cycle T+RD_LAT+1 (T+3 at default).
REQ-022 SHALL return results strictly in acceptance order; no reordering, drop or duplication.
REQ-023 SHALL keep a credit counter = FIFO occupancy + in-flight count, range 0..FIFO_DEPTH; +1 on accept, -1 on pop, unchanged on simultaneous accept and pop.
REQ-024 SHALL assert in_ready iff reset is low and the credit counter < FIFO_DEPTH; in_ready SHALL have no combinational path from out_ready or in_valid.
REQ-025 SHALL never overflow the FIFO; a rom_q write into a full FIFO is a design error flagged by assertion.
REQ-026 SHALL present the FIFO head on out_data/out_tag with out_valid = FIFO non-empty; out_data/out_tag SHALL hold stable while out_valid && !out_ready.
REQ-027 SHALL sustain one accept and one result per cycle indefinitely when FIFO_DEPTH >= RD_LAT+2 and out_ready is held high.
REQ-028 SHALL handle FIFO pointer wrap-around by modulo FIFO_DEPTH; non-power-of-2 depths SHALL be supported.
REQ-029 SHALL, on simultaneous FIFO write and pop with FIFO empty, not bypass: the written entry appears on out_valid the following cycle.

Reset
REQ-030 SHALL, while reset is high, hold in_ready=0, out_valid=0, out_data=0, out_tag=0, credit counter=0, all pipeline valids=0, FIFO pointers=0.
REQ-031 SHALL, on reset mid-operation, discard all in-flight and buffered results; rom_q returning after reset deasserts SHALL NOT produce outputs.
REQ-032 SHALL assert in_ready in the first cycle after reset deasserts.

Verification
REQ-033 Single lookup: ROM mem[0x05]=0xA5, in_addr=0x05, in_tag=3 accepted cycle T -> out_valid=1, out_data=0xA5, out_tag=3 in cycle T+3 only.
REQ-034 Streaming: 8 back-to-back requests addr 0..7, out_ready=1 -> in_ready never drops, 8 results in order on 8 consecutive cycles.
REQ-035 Backpressure: out_ready=0, in_valid=1 continuous -> exactly 4 accepts then in_ready=0; raise out_ready -> 4 results in order, in_ready=1 the cycle after the first pop.
REQ-036 Full with accept+pop: credit=4, out_ready=1 for one cycle -> in_ready rises next cycle; credit returns to 4 after that accept; no overflow assertion fires.
REQ-037 Reset mid-flight: 2 requests in pipeline, 1 in FIFO, reset pulsed 1 cycle -> out_valid stays 0 for 5 subsequent cycles, in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/rom_rd_ctrl.sv
// ROM lookup controller: tracks accepted requests through the ROM read
// latency and buffers results with their tags in a credit-guarded FIFO.
module rom_rd_ctrl #(
  parameter int AWIDTH     = 8,
  parameter int DWIDTH     = 8,
  parameter int TWIDTH     = 4,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [TWIDTH-1:0] in_tag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_q,
  output logic [DWIDTH-1:0] out_data,
  output logic [TWIDTH-1:0] out_tag,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CMAX  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(FIFO_DEPTH - 1);

  logic [CW-1:0]     credit;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [TWIDTH-1:0] mem_t [FIFO_DEPTH];
  logic [RD_LAT-1:0] pv;
  logic [TWIDTH-1:0] pt [RD_LAT];
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  assign rom_addr  = in_addr;
  assign in_ready  = !reset && (credit < CMAX);
  assign accept    = in_valid && in_ready;
  assign push      = pv[RD_LAT-1];
  assign out_valid = !reset && (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
  assign out_tag   = out_valid ? mem_t[rd_ptr] : '0;

  // Credit = buffered + in-flight results; bounds outstanding requests
  always_ff @(posedge clock) begin
    if (reset) begin
      credit <= '0;
    end else if (accept && !pop) begin
      credit <= credit + 1'b1;
    end else if (pop && !accept) begin
      credit <= credit - 1'b1;
    end
  end

  // Valid shift pipeline marking which ROM reads belong to accepted requests
  always_ff @(posedge clock) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  // Tag shift pipeline running alongside the valid bits
  always_ff @(posedge clock) begin
    pt[0] <= in_tag;
    for (int i = 1; i < RD_LAT; i++) pt[i] <= pt[i-1];
  end

  // FIFO storage written when the last pipeline stage qualifies rom_q
  always_ff @(posedge clock) begin
    if (push) begin
      mem_d[wr_ptr] <= rom_q;
      mem_t[wr_ptr] <= pt[RD_LAT-1];
    end
  end

  // FIFO pointers and occupancy; no bypass from write to head
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Credits should make a write into a full FIFO impossible
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      assert (count < CMAX);
    end
  end

endmodule
